// File: rtl/riio_gpi_ctrl.sv
// riio_gpi_ctrl: GPI pull-up pad controller - input-enable settle sequencing, Schmitt config,
// 2-flop sync, debounce and edge interrupt. Edge/IRQ logic is built only with RIIO_GPI_CTRL_IRQ_EN.
module riio_gpi_ctrl #(
   parameter int DEB_W      = 8,
   parameter int SETTLE_CYC = 4
) (
   input  logic             CLK_I,
   input  logic             RSTN_I,
   input  logic             EN_I,
   input  logic [1:0]       STE_CFG_I,
   input  logic [DEB_W-1:0] DEB_LIM_I,
   input  logic [1:0]       IRQ_MODE_I,
   input  logic             IRQ_CLR_I,
   input  logic [1:0]       PAD_DI_I,
   output logic             PAD_IE_O,
   output logic [1:0]       PAD_STE_O,
   output logic             LEVEL_O,
   output logic             VALID_O,
   output logic             EDGE_O,
   output logic             IRQ_O
);

   localparam int SETTLE_EFF = (SETTLE_CYC < 2) ? 2 : SETTLE_CYC;
   localparam int SET_W      = $clog2(SETTLE_EFF);
   localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_EFF - 1);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SET_W-1:0]   r_settle;
   logic [SET_W-1:0]   w_settle_nxt;
   logic [DEB_W-1:0]   r_cnt;
   logic [DEB_W-1:0]   w_cnt_nxt;
   logic               r_level;
   logic               w_level_nxt;
   logic               r_valid;
   logic               w_valid_nxt;
   logic               r_ie;
   logic               w_ie_nxt;
   logic [1:0]         r_ste;
   logic [1:0]         w_ste_nxt;
   logic               r_sync1;
   logic               r_sync2;
   logic               w_chg;
   logic               w_rise;
   logic [DEB_W:0]     w_lim_eff;
   logic [DEB_W:0]     w_cnt_inc;

   // One extra bit keeps count+1 from wrapping when the limit is at its maximum.
   assign w_lim_eff = (DEB_LIM_I == {DEB_W{1'b0}}) ? {{DEB_W{1'b0}}, 1'b1} : {1'b0, DEB_LIM_I};
   assign w_cnt_inc = {1'b0, r_cnt} + {{DEB_W{1'b0}}, 1'b1};

   // Next-state, settle countdown and debounce decisions
   always_comb begin
      w_state_nxt  = r_state;
      w_settle_nxt = r_settle;
      w_cnt_nxt    = r_cnt;
      w_level_nxt  = r_level;
      w_valid_nxt  = r_valid;
      w_ie_nxt     = r_ie;
      w_ste_nxt    = r_ste;
      w_chg        = 1'b0;
      w_rise       = 1'b0;
      case (r_state)
         ST_OFF: begin
            w_valid_nxt = 1'b0;
            w_level_nxt = 1'b0;
            w_cnt_nxt   = {DEB_W{1'b0}};
            if (EN_I) begin
               w_state_nxt  = ST_SETTLE;
               w_ste_nxt    = STE_CFG_I;
               w_settle_nxt = SETTLE_LOAD;
               w_ie_nxt     = 1'b1;
            end else begin
               w_state_nxt  = ST_OFF;
               w_ie_nxt     = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (!EN_I) begin
               w_state_nxt = ST_OFF;
               w_ie_nxt    = 1'b0;
            end else if (r_settle == {SET_W{1'b0}}) begin
               w_state_nxt = ST_ACTIVE;
               w_valid_nxt = 1'b1;
               w_level_nxt = r_sync2;
               w_cnt_nxt   = {DEB_W{1'b0}};
            end else begin
               w_settle_nxt = r_settle - SET_W'(1);
            end
         end
         ST_ACTIVE: begin
            if (!EN_I) begin
               w_state_nxt = ST_OFF;
               w_ie_nxt    = 1'b0;
               w_valid_nxt = 1'b0;
               w_level_nxt = 1'b0;
               w_cnt_nxt   = {DEB_W{1'b0}};
            end else if (r_sync2 == r_level) begin
               w_cnt_nxt   = {DEB_W{1'b0}};
            end else if (w_cnt_inc >= w_lim_eff) begin
               w_level_nxt = r_sync2;
               w_cnt_nxt   = {DEB_W{1'b0}};
               w_chg       = 1'b1;
               w_rise      = r_sync2;
            end else begin
               w_cnt_nxt   = w_cnt_inc[DEB_W-1:0];
            end
         end
         default: begin
            w_state_nxt = ST_OFF;
            w_ie_nxt    = 1'b0;
            w_valid_nxt = 1'b0;
            w_level_nxt = 1'b0;
            w_cnt_nxt   = {DEB_W{1'b0}};
         end
      endcase
   end

   // State, sequencing, synchroniser and debounce registers
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         r_state  <= ST_OFF;
         r_settle <= {SET_W{1'b0}};
         r_cnt    <= {DEB_W{1'b0}};
         r_level  <= 1'b0;
         r_valid  <= 1'b0;
         r_ie     <= 1'b0;
         r_ste    <= 2'b00;
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_settle <= w_settle_nxt;
         r_cnt    <= w_cnt_nxt;
         r_level  <= w_level_nxt;
         r_valid  <= w_valid_nxt;
         r_ie     <= w_ie_nxt;
         r_ste    <= w_ste_nxt;
         r_sync1  <= PAD_DI_I[0];
         r_sync2  <= r_sync1;
      end
   end

   assign PAD_IE_O  = r_ie;
   assign PAD_STE_O = r_ste;
   assign LEVEL_O   = r_level;
   assign VALID_O   = r_valid;

`ifdef RIIO_GPI_CTRL_IRQ_EN
   logic r_chg;
   logic r_rise;
   logic r_edge;
   logic r_irq;
   logic w_unused;

   assign w_unused = PAD_DI_I[1];

   // Qualified edge pulse one cycle after a level change; sticky IRQ where set beats clear
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         r_chg  <= 1'b0;
         r_rise <= 1'b0;
         r_edge <= 1'b0;
         r_irq  <= 1'b0;
      end else begin
         r_chg  <= w_chg;
         r_rise <= w_rise;
         r_edge <= r_chg & ((r_rise & IRQ_MODE_I[0]) | (!r_rise & IRQ_MODE_I[1]));
         r_irq  <= r_edge | (r_irq & !IRQ_CLR_I);
      end
   end

   assign EDGE_O = r_edge;
   assign IRQ_O  = r_irq;
`else
   logic w_unused;

   assign w_unused = ^{PAD_DI_I[1], IRQ_MODE_I, IRQ_CLR_I, w_chg, w_rise};
   assign EDGE_O   = 1'b0;
   assign IRQ_O    = 1'b0;
`endif

endmodule
